multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore FSM control unit for the multi-cycle MIPS datapath (shared memory, IR, ALUOut); successor to the single-cycle decoder.
- Sequences each instruction over 3–5+ cycles and waits on a memory-ready handshake with timeout.
- Flags illegal opcodes and functs, and reports instruction completion.
- Supports R-type add/sub/and/or/xor, lw, sw, beq and lui.

Parameters:
- ALU_OP_W, 3, width of ALU_op; codes below are zero-extended when ALU_OP_W > 3.
- WAIT_MAX, 15, maximum cycles spent waiting on mem_ready before a bus error; 0 disables the timeout.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- op  in  6  IR[31:26]; stable from the cycle after FETCH completes.
- func  in  6  IR[5:0].
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- IRWrite  out  1  load IR.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- MemtoReg  out  1  register write data source: 1 = MDR, 0 = ALUOut.
- RegDst  out  1  destination register: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  00 rt, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
- ALU_op  out  ALU_OP_W  000 add, 100 sub, 001 and, 101 or, 010 xor, 110 lui.
- illegal  out  1  one-cycle pulse: undecodable instruction.
- bus_err  out  1  one-cycle pulse: mem_ready timeout.
- instr_done  out  1  one-cycle pulse: instruction retired.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=FETCH(0), wait_cnt=0; illegal, bus_err, instr_done = 0.
  - While rst is high, all strobes are forced to 0: PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite.
  - Reset mid-instruction abandons the instruction with no write strobe.
- Outputs are combinational from the state register. Any output not listed for a state is 0. ALU_op defaults to 000.
- FETCH(0):
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, IRWrite=mem_ready, PCWrite=mem_ready.
  - mem_ready=1 -> DECODE; else stay.
- DECODE(1):
  - Outputs: ALUSrcA=0, ALUSrcB=11.
  - Next state by op: 000000 with legal func -> R_EXEC; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 001111 -> LUI_EXEC.
  - Any other op/func -> FETCH, with illegal=1 next cycle.
- MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10. lw -> MEM_RD(3); sw -> MEM_WR(5).
- MEM_RD(3): IorD=1, MemRead=1. mem_ready -> MEM_WB(4).
- MEM_WB(4): RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEM_WR(5): IorD=1, MemWrite=1. mem_ready -> FETCH.
- R_EXEC(6):
  - Outputs: ALUSrcA=1, ALUSrcB=00.
  - ALU_op by func: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor.
  - -> R_WB(7).
- R_WB(7): RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALU_op=100, PCWriteCond=1, PCSource=01 -> FETCH.
- LUI_EXEC(9): ALUSrcA=1, ALUSrcB=10, ALU_op=110 -> LUI_WB(10).
- LUI_WB(10): RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- instr_done pulses the cycle after leaving MEM_WB, MEM_WR, R_WB, BRANCH, LUI_WB or JUMP for FETCH. It does not pulse on illegal or bus_err.
- Latency with mem_ready=1 (FETCH to next FETCH): lw 5, sw 4, R-type 4, lui 4, beq 3.
- Wait counter:
  - wait_cnt clears on entering FETCH, MEM_RD or MEM_WR.
  - It increments each cycle in those states while mem_ready=0.
  - Timeout condition: WAIT_MAX≠0 and wait_cnt==WAIT_MAX-1 and mem_ready=0. The state goes to FETCH with counter cleared, and bus_err=1 next cycle.
  - On timeout, no IRWrite, PCWrite, RegWrite or MemWrite occurs for that access.
  - mem_ready=1 in the timeout cycle counts as success; it is not a timeout.
- A timeout in FETCH restarts FETCH with the same PC.

Optional Feature:
- JUMP_EN defined:
  - op 000010 in DECODE -> JUMP(11): PCWrite=1, PCSource=10 -> FETCH, then instr_done.
  - j latency is 3 cycles.
- JUMP_EN undefined: op 000010 is illegal (FETCH, illegal pulse), and state 11 is unreachable.

Test Plan:
- Reset, then op=100011, mem_ready=1 throughout -> states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. instr_done pulses once.
- op=000000, func=100010 -> states 0,1,6,7,0. ALU_op=100 in state 6. RegDst=1 and RegWrite=1 in state 7.
- op=101011 with mem_ready low for 3 cycles in MEM_WR -> MemWrite held high 4 cycles, then FETCH and instr_done. bus_err stays 0.
- mem_ready held 0 in FETCH, WAIT_MAX=15 -> after 15 cycles returns to FETCH, bus_err pulses once, IRWrite never asserted.
- op=000000, func=101010, then op=111111 -> each returns to FETCH from DECODE with an illegal pulse, no RegWrite, no instr_done.
- op=000010 -> with JUMP_EN: states 0,1,11,0, PCWrite=1 and PCSource=10 in state 11. Without JUMP_EN: illegal pulse. Assert rst during MEM_RD -> next cycle state=0 and all strobes 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Moore-style control FSM for the multi-cycle MIPS datapath (shared memory,
// IR, ALUOut). Each instruction is sequenced over several cycles; memory
// accesses wait on mem_ready, with an optional timeout that raises bus_err.
// Undecodable instructions raise illegal; retired instructions pulse
// instr_done.
//
// Supported: R-type add/sub/and/or/xor, lw, sw, beq, lui
//            (+ j when the JUMP_EN macro is defined).
//
// Optional feature macro: JUMP_EN
//   defined   : op 000010 decodes to JUMP (state 11).
//   undefined : op 000010 is illegal; state 11 is unreachable.
//
// Parameters:
//   ALU_OP_W  width of ALU_op (3-bit codes zero-extended)
//   WAIT_MAX  max cycles waiting on mem_ready before bus error (0 = never)
//   CNT_W     wait counter width, 2**CNT_W > WAIT_MAX
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   op, func       IR[31:26], IR[5:0]
//   mem_ready      memory access completes this cycle
//   PCWrite, PCWriteCond, PCSource, IorD, IRWrite, MemRead, MemWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALU_op
//                  datapath controls, decoded from the current state
//   illegal        one-cycle pulse: undecodable instruction
//   bus_err        one-cycle pulse: mem_ready timeout
//   instr_done     one-cycle pulse: instruction retired
//   state_dbg      current state encoding
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int ALU_OP_W = 3,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op,
    input  logic [5:0]          func,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic [1:0]          PCSource,
    output logic                IorD,
    output logic                IRWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALU_OP_W-1:0] ALU_op,
    output logic                illegal,
    output logic                bus_err,
    output logic                instr_done,
    output logic [3:0]          state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        LUI_EXEC = 4'd9,
        LUI_WB   = 4'd10,
        JUMP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b110;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic               done_q, done_d;

    logic               wait_state;
    logic               timeout;
    logic               func_legal;
    logic [2:0]         alu_sel;

    always_comb begin
        func_legal = 1'b0;
        case (func)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR: func_legal = 1'b1;
            default:                               func_legal = 1'b0;
        endcase
    end

    // States that wait on mem_ready share one counter; a timeout is only
    // declared when the memory is still not ready in the final allowed cycle.
    assign wait_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign timeout    = (WAIT_MAX != 0) && wait_state && !mem_ready &&
                        (wait_cnt_q == CNT_W'(WAIT_MAX - 1));

    // ------------------------------------------------------------------
    // Next-state and pulse logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        bus_err_d = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d   = FETCH;
                    bus_err_d = 1'b1;
                end
            end
            DECODE: begin
                if (op == OP_RTYPE && func_legal) begin
                    state_d = R_EXEC;
                end else if (op == OP_LW || op == OP_SW) begin
                    state_d = MEM_ADDR;
                end else if (op == OP_BEQ) begin
                    state_d = BRANCH;
                end else if (op == OP_LUI) begin
                    state_d = LUI_EXEC;
`ifdef JUMP_EN
                end else if (op == OP_J) begin
                    state_d = JUMP;
`endif
                end else begin
                    state_d   = FETCH;
                    illegal_d = 1'b1;
                end
            end
            MEM_ADDR: begin
                state_d = (op == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                if (mem_ready) begin
                    state_d = MEM_WB;
                end else if (timeout) begin
                    state_d   = FETCH;
                    bus_err_d = 1'b1;
                end
            end
            MEM_WB: begin
                state_d = FETCH;
                done_d  = 1'b1;
            end
            MEM_WR: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    done_d  = 1'b1;
                end else if (timeout) begin
                    state_d   = FETCH;
                    bus_err_d = 1'b1;
                end
            end
            R_EXEC:   state_d = R_WB;
            R_WB: begin
                state_d = FETCH;
                done_d  = 1'b1;
            end
            BRANCH: begin
                state_d = FETCH;
                done_d  = 1'b1;
            end
            LUI_EXEC: state_d = LUI_WB;
            LUI_WB: begin
                state_d = FETCH;
                done_d  = 1'b1;
            end
            JUMP: begin
                state_d = FETCH;
                done_d  = 1'b1;
            end
            default:  state_d = FETCH;
        endcase
    end

    // Counting only while staying in a wait state means any entry into one
    // (including a timeout re-entry of FETCH) starts from zero.
    always_comb begin
        wait_cnt_d = '0;
        if (wait_state && !mem_ready && !timeout) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath controls (decoded from the state register)
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        alu_sel     = ALU_ADD;

        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            MEM_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            R_EXEC: begin
                ALUSrcA = 1'b1;
                case (func)
                    FN_SUB:  alu_sel = ALU_SUB;
                    FN_AND:  alu_sel = ALU_AND;
                    FN_OR:   alu_sel = ALU_OR;
                    FN_XOR:  alu_sel = ALU_XOR;
                    default: alu_sel = ALU_ADD;
                endcase
            end
            R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                alu_sel     = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            LUI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_sel = ALU_LUI;
            end
            LUI_WB: begin
                RegWrite = 1'b1;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase

        // Reset mid-instruction must not let any write or request escape.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign ALU_op     = ALU_OP_W'(alu_sel);
    assign illegal    = illegal_q;
    assign bus_err    = bus_err_q;
    assign instr_done = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Instruction-level bench: each instruction is expanded into the sequence of
// states it should walk through (including memory wait cycles and
// timeouts), and every cycle the DUT state, control word and status pulses
// are compared against a table of per-state controls.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, func;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] PCSource, ALUSrcB;
    logic [2:0] ALU_op;
    logic       illegal, bus_err, instr_done;
    logic [3:0] state_dbg;

    int total = 0;
    int bad   = 0;
    bit p_ill, p_be, p_done;

    multicycle_control_unit #(
        .ALU_OP_W (3),
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .func        (func),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSource    (PCSource),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALU_op      (ALU_op),
        .illegal     (illegal),
        .bus_err     (bus_err),
        .instr_done  (instr_done),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Control word expected in state s, from the per-state output lists.
    function automatic logic [16:0] model_ctrl(input int s, input logic mr, input logic [5:0] f);
        logic       pcw, pcc, iord, irw, mrd, mwr, m2r, rdst, rw, srca;
        logic [1:0] pcs, srcb;
        logic [2:0] alu;
        pcw = 0; pcc = 0; iord = 0; irw = 0; mrd = 0; mwr = 0;
        m2r = 0; rdst = 0; rw = 0; srca = 0; pcs = 0; srcb = 0; alu = 0;
        case (s)
            0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin iord = 1; mrd = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mwr = 1; end
            6:  begin
                    srca = 1;
                    if (f == 6'h22) alu = 3'b100;
                    else if (f == 6'h24) alu = 3'b001;
                    else if (f == 6'h25) alu = 3'b101;
                    else if (f == 6'h26) alu = 3'b010;
                    else alu = 3'b000;
                end
            7:  begin rdst = 1; rw = 1; end
            8:  begin srca = 1; alu = 3'b100; pcc = 1; pcs = 2'b01; end
            9:  begin srca = 1; srcb = 2'b10; alu = 3'b110; end
            10: rw = 1;
            11: begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pcw, pcc, pcs, iord, irw, mrd, mwr, m2r, rdst, rw, srca, srcb, alu};
    endfunction

    // 0 illegal, 1 lw, 2 sw, 3 R-type, 4 beq, 5 lui, 6 j
    function automatic int kind(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00:   return (f == 6'h20 || f == 6'h22 || f == 6'h24 ||
                             f == 6'h25 || f == 6'h26) ? 3 : 0;
            6'h23:   return 1;
            6'h2b:   return 2;
            6'h04:   return 4;
            6'h0f:   return 5;
`ifdef JUMP_EN
            6'h02:   return 6;
`endif
            default: return 0;
        endcase
    endfunction

    // One clock cycle: drive inputs at negedge, check shortly after.
    task automatic cyc(input int s, input logic mr, input logic [5:0] o, input logic [5:0] fn);
        @(negedge clk);
        mem_ready = mr;
        op        = o;
        func      = fn;
        #1;
        check_val("state", 32'(state_dbg), 32'(s));
        check_val("ctrl", 32'({PCWrite, PCWriteCond, PCSource, IorD, IRWrite, MemRead,
                               MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
                               ALU_op}), 32'(model_ctrl(s, mr, fn)));
        check_val("pulses", 32'({illegal, bus_err, instr_done}), 32'({p_ill, p_be, p_done}));
        p_ill  = 0;
        p_be   = 0;
        p_done = 0;
        @(posedge clk);
    endtask

    // Memory access that stalls for 'waits' cycles; a stall reaching
    // WAIT_MAX cycles is a timeout.
    task automatic mem_access(input int s, input int waits, input logic [5:0] o,
                              input logic [5:0] fn, output bit ok);
        for (int i = 0; i < waits && i < WAIT_MAX; i++) cyc(s, 1'b0, o, fn);
        if (waits >= WAIT_MAX) begin
            ok   = 0;
            p_be = 1;
        end else begin
            cyc(s, 1'b1, o, fn);
            ok = 1;
        end
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] fn,
                             input int fw, input int mw);
        bit ok;
        mem_access(0, fw, 6'($urandom), 6'($urandom), ok);
        while (!ok) mem_access(0, int'($urandom_range(0, 2)), 6'($urandom), 6'($urandom), ok);
        cyc(1, 1'($urandom), o, fn);
        case (kind(o, fn))
            1: begin
                cyc(2, 1'($urandom), o, fn);
                mem_access(3, mw, o, fn, ok);
                if (ok) begin
                    cyc(4, 1'($urandom), o, fn);
                    p_done = 1;
                end
            end
            2: begin
                cyc(2, 1'($urandom), o, fn);
                mem_access(5, mw, o, fn, ok);
                if (ok) p_done = 1;
            end
            3: begin
                cyc(6, 1'($urandom), o, fn);
                cyc(7, 1'($urandom), o, fn);
                p_done = 1;
            end
            4: begin
                cyc(8, 1'($urandom), o, fn);
                p_done = 1;
            end
            5: begin
                cyc(9, 1'($urandom), o, fn);
                cyc(10, 1'($urandom), o, fn);
                p_done = 1;
            end
            6: begin
                cyc(11, 1'($urandom), o, fn);
                p_done = 1;
            end
            default: p_ill = 1;
        endcase
    endtask

    task automatic reset_in_mem_rd();
        bit ok;
        mem_access(0, 0, 6'h23, 6'h00, ok);
        cyc(1, 1'b1, 6'h23, 6'h00);
        cyc(2, 1'b1, 6'h23, 6'h00);
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_val("rst_state_before", 32'(state_dbg), 32'd3);
        check_val("rst_strobes", 32'({PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_state_after", 32'(state_dbg), 32'd0);
        check_val("rst_pulses", 32'({illegal, bus_err, instr_done}), 32'd0);
        p_ill  = 0;
        p_be   = 0;
        p_done = 0;
    endtask

    logic [5:0] op_pool [7];
    logic [5:0] fn_pool [5];

    initial begin
        rst = 1'b1; op = '0; func = '0; mem_ready = 1'b0;
        p_ill = 0; p_be = 0; p_done = 0;
        op_pool = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h0f, 6'h02, 6'h00};
        fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("reset_state", 32'(state_dbg), 32'd0);
        check_val("reset_pulses", 32'({illegal, bus_err, instr_done}), 32'd0);
        check_val("reset_strobes", 32'({PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases
        run_instr(6'h23, 6'h00, 0, 0);     // lw
        run_instr(6'h00, 6'h22, 0, 0);     // sub
        run_instr(6'h2b, 6'h00, 0, 3);     // sw, 3 stall cycles
        run_instr(6'h0f, 6'h00, 15, 0);    // fetch timeout, then lui
        run_instr(6'h04, 6'h00, 14, 0);    // ready in last allowed fetch cycle
        run_instr(6'h00, 6'h2a, 0, 0);     // illegal funct
        run_instr(6'h3f, 6'h00, 0, 0);     // illegal op
        run_instr(6'h02, 6'h00, 0, 0);     // j
        run_instr(6'h23, 6'h00, 1, 15);    // lw timeout in MEM_RD
        run_instr(6'h2b, 6'h00, 0, 14);    // sw ready in last allowed cycle
        run_instr(6'h2b, 6'h00, 0, 16);    // sw timeout
        run_instr(6'h00, 6'h26, 2, 0);     // xor
        reset_in_mem_rd();

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            logic [5:0] o, f;
            int fw, mw, pick;
            pick = int'($urandom_range(0, 7));
            o    = (pick == 7) ? 6'($urandom) : op_pool[pick];
            f    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 4)];
            fw   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 3));
            mw   = ($urandom_range(0, 10) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 3));
            run_instr(o, f, fw, mw);
            if (n == 100) reset_in_mem_rd();
        end

        // Consume any pulse left pending by the last instruction.
        cyc(0, 1'b0, 6'h00, 6'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
